// File: rtl/pdm_pkg.sv
// Shared PDM definitions: CIC order, default sample width, width and scaling helpers.
`timescale 1ns/1ps
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int PDM_NBITS = 16;

  function automatic int cic_width(input int order, input int decim_log2);
    return order * decim_log2 + 1;
  endfunction

  // Drop the sh LSBs of an unsigned comb result and clamp to nbits-wide full scale.
  function automatic logic [63:0] sat_shift(input logic [63:0] c, input int sh, input int nbits);
    logic [63:0] y;
    logic [63:0] full;
    y    = c >> sh;
    full = (64'd1 << nbits) - 64'd1;
    return (y > full) ? full : y;
  endfunction

endpackage

// File: rtl/pdm_demod_cic_integrator.sv
// One CIC integrator: modulo-2^W accumulator that advances only when enabled.
`timescale 1ns/1ps
module cic_integrator
  import pdm_pkg::*;
#(
  parameter int W = cic_width(CIC_ORDER, 6)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] acc,
  output logic [W-1:0] acc_next
);

  // Wrap-around is part of CIC arithmetic; the combs undo it.
  assign acc_next = acc + add;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pdm_demod.sv
// PDM to PCM demodulator: 3rd-order CIC decimator by 2^DECIM_LOG2, scaled and saturated.
// Optional build macro PDM_DEMOD_SETTLE_EN suppresses the two warm-up output strobes.
`timescale 1ns/1ps
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int NBITS      = PDM_NBITS,
  parameter int DECIM_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid
);

  localparam int W  = cic_width(CIC_ORDER, DECIM_LOG2);
  localparam int SH = CIC_ORDER * DECIM_LOG2 - NBITS;

  if (CIC_ORDER * DECIM_LOG2 < NBITS) begin : g_bad_cfg
    $error("pdm_demod: 3*DECIM_LOG2 must be >= NBITS");
  end

  logic [W-1:0]          din_ext;
  logic [W-1:0]          i1, i2, i3;
  logic [W-1:0]          i1_next, i2_next, i3_next;
  logic [DECIM_LOG2-1:0] bit_cnt;
  logic                  tick_p0;

  assign din_ext = {{(W-1){1'b0}}, din};

  cic_integrator #(.W(W)) u_int1 (
    .clk(clk), .rst(rst), .en(din_en), .add(din_ext), .acc(i1), .acc_next(i1_next)
  );
  cic_integrator #(.W(W)) u_int2 (
    .clk(clk), .rst(rst), .en(din_en), .add(i1_next), .acc(i2), .acc_next(i2_next)
  );
  cic_integrator #(.W(W)) u_int3 (
    .clk(clk), .rst(rst), .en(din_en), .add(i2_next), .acc(i3), .acc_next(i3_next)
  );

  // Stage p0: the tick flag marks the edge that accepted the last bit of a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      tick_p0 <= 1'b0;
    end else begin
      tick_p0 <= din_en && (&bit_cnt);
      if (din_en) begin
        bit_cnt <= bit_cnt + DECIM_LOG2'(1);
      end
    end
  end

  logic signed [W-1:0] x_p1, x_prev;
  logic signed [W-1:0] c1_p2, c1_prev;
  logic signed [W-1:0] c2_p3, c2_prev;
  logic signed [W-1:0] c3_p4;
  logic                vld_p1, vld_p2, vld_p3, vld_p4;

  // Stages p1..p4: capture I3, then three combs; each delay register moves only with its own valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      vld_p4  <= 1'b0;
      x_p1    <= '0;
      x_prev  <= '0;
      c1_p2   <= '0;
      c1_prev <= '0;
      c2_p3   <= '0;
      c2_prev <= '0;
      c3_p4   <= '0;
    end else begin
      vld_p1 <= tick_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      if (tick_p0) begin
        x_p1 <= $signed(i3);
      end
      if (vld_p1) begin
        c1_p2  <= x_p1 - x_prev;
        x_prev <= x_p1;
      end
      if (vld_p2) begin
        c2_p3   <= c1_p2 - c1_prev;
        c1_prev <= c1_p2;
      end
      if (vld_p3) begin
        c3_p4   <= c2_p3 - c2_prev;
        c2_prev <= c2_p3;
      end
    end
  end

  // The comb result is non-negative in true arithmetic, so reading it unsigned is exact.
  logic [63:0] scaled;
  assign scaled = sat_shift(64'($unsigned(c3_p4)), SH, NBITS);

  // Stage p5: output register and strobe.
`ifdef PDM_DEMOD_SETTLE_EN
  logic [1:0] settle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 2'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (vld_p4) begin
        if (settle_cnt == 2'd2) begin
          dout       <= scaled[NBITS-1:0];
          dout_valid <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= vld_p4;
      if (vld_p4) begin
        dout <= scaled[NBITS-1:0];
      end
    end
  end
`endif

  // Registered I1/I2, the last next-value and the scaler's headroom bits have no consumer.
  logic unused_ok;
  assign unused_ok = &{1'b0, i1, i2, i3_next, scaled[63:NBITS]};

endmodule

// File: tb/tb_pdm_demod.sv
// Randomized bench for pdm_demod against a triangular-impulse-response CIC reference model.
`timescale 1ns/1ps
module tb_pdm_demod;

  localparam int NBITS      = 16;
  localparam int DECIM_LOG2 = 6;
  localparam int R          = 64;
  localparam int SH         = 3 * DECIM_LOG2 - NBITS;
  localparam int HLEN       = 3 * R - 2;
`ifdef PDM_DEMOD_SETTLE_EN
  localparam int SKIP = 2;
`else
  localparam int SKIP = 0;
`endif

  typedef struct {
    int cyc;
    int val;
  } strobe_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_en = 1'b0;
  logic [NBITS-1:0] dout;
  logic             dout_valid;

  strobe_t exp_q[$];
  strobe_t obs_q[$];
  int      h[HLEN];
  int      hist[$];
  int      nacc = 0;
  int      cyc = 0;
  int      nvec = 0;
  int      nfail = 0;

  pdm_demod #(.NBITS(NBITS), .DECIM_LOG2(DECIM_LOG2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dout_valid === 1'b1) obs_q.push_back('{cyc, int'(dout)});

  // CIC^3 with decimation R is a convolution of three length-R boxcars.
  function automatic void build_h();
    int h2[2*R-1];
    foreach (h2[i]) h2[i] = 0;
    foreach (h[i]) h[i] = 0;
    for (int i = 0; i < R; i++) for (int j = 0; j < R; j++) h2[i+j]++;
    for (int i = 0; i < 2*R-1; i++) for (int j = 0; j < R; j++) h[i+j] += h2[i];
  endfunction

  function automatic int model_out();
    longint acc = 0;
    int n = hist.size();
    for (int j = 0; j < HLEN && j < n; j++) acc += longint'(h[j] * hist[n-1-j]);
    acc = acc >>> SH;
    if (acc > longint'((1 << NBITS) - 1)) acc = longint'((1 << NBITS) - 1);
    return int'(acc);
  endfunction

  // One clock of stimulus; also advances the reference model.
  task automatic drive(input logic b, input logic en, input logic r);
    int p;
    @(negedge clk);
    din = b; din_en = en; rst = r;
    p = cyc + 1;
    if (r) begin
      hist.delete();
      nacc = 0;
      while (exp_q.size() > 0 && exp_q[$].cyc >= p) void'(exp_q.pop_back());
    end else if (en) begin
      hist.push_back(int'(b));
      nacc++;
      if (nacc % R == 0 && nacc / R > SKIP) exp_q.push_back('{p + 5, model_out()});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (dout !== '0) begin nfail++; $display("FAIL reset_dout: got %h expected 0000", dout); end
    nvec++;
    if (dout_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
  endtask

  task automatic test_zero();
    do_reset();
    for (int i = 0; i < 4*R; i++) drive(1'b0, 1'b1, 1'b0);
    idle(8);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL zero_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val) begin
        nfail++; $display("FAIL zero[%0d]: got cyc %0d val %h expected cyc %0d val %h", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      end
    end
    for (int i = 1; i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc - obs_q[i-1].cyc != R || obs_q[i].val != 0) begin
        nfail++; $display("FAIL zero_spacing[%0d]: got gap %0d val %h expected gap %0d val 0000", i, obs_q[i].cyc - obs_q[i-1].cyc, obs_q[i].val, R);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ones();
    do_reset();
    for (int i = 0; i < 4*R; i++) drive(1'b1, 1'b1, 1'b0);
    idle(8);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL ones_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val) begin
        nfail++; $display("FAIL ones[%0d]: got cyc %0d val %h expected cyc %0d val %h", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      end
    end
    for (int i = 2 - SKIP; i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].val != 32'hFFFF) begin nfail++; $display("FAIL ones_sat[%0d]: got %h expected ffff", i, obs_q[i].val); end
    end
    nvec++;
    if (dout !== 16'hFFFF) begin nfail++; $display("FAIL ones_hold: got %h expected ffff", dout); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 5*R; i++) drive(logic'(i % 2 == 0), 1'b1, 1'b0);
    idle(8);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL alt_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val) begin
        nfail++; $display("FAIL alt[%0d]: got cyc %0d val %h expected cyc %0d val %h", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      end
    end
    for (int i = 2 - SKIP; i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].val != 32'h8000) begin nfail++; $display("FAIL alt_mid[%0d]: got %h expected 8000", i, obs_q[i].val); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // First-order sigma-delta stands in for the modulator; duty is exactly 0x4000/2^16.
  task automatic test_loopback();
    logic [16:0] macc;
    do_reset();
    macc = '0;
    for (int i = 0; i < 6*R; i++) begin
      macc = {1'b0, macc[15:0]} + 17'h04000;
      drive(macc[16], 1'b1, 1'b0);
    end
    idle(8);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL loop_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val) begin
        nfail++; $display("FAIL loop[%0d]: got cyc %0d val %h expected cyc %0d val %h", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      end
    end
    for (int i = 2 - SKIP; i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].val < 32'h3FFF || obs_q[i].val > 32'h4001) begin
        nfail++; $display("FAIL loop_range[%0d]: got %h expected 4000+-1", i, obs_q[i].val);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_gapped();
    do_reset();
    for (int i = 0; i < 3*4*R; i++) drive(1'b1, logic'(i % 3 == 2), 1'b0);
    idle(8);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL gap_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val) begin
        nfail++; $display("FAIL gap[%0d]: got cyc %0d val %h expected cyc %0d val %h", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    do_reset();
    while (nacc < 6*R) drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0), 1'b0);
    idle(8);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL rand_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val) begin
        nfail++; $display("FAIL rand[%0d]: got cyc %0d val %h expected cyc %0d val %h", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Reset lands on an in-flight pipeline, then mid-frame; rst also collides with din_en.
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < R + 1; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    nvec++;
    if (dout !== '0) begin nfail++; $display("FAIL mid_reset_dout: got %h expected 0000", dout); end
    for (int i = 0; i < 3*R; i++) drive(1'b1, 1'b1, 1'b0);
    idle(8);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL mid_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val) begin
        nfail++; $display("FAIL mid[%0d]: got cyc %0d val %h expected cyc %0d val %h", i, obs_q[i].cyc, obs_q[i].val, exp_q[i].cyc, exp_q[i].val);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_h();
    test_reset();
    test_zero();
    test_ones();
    test_alternating();
    test_loopback();
    test_gapped();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pdm_demod.md
Name: pdm_demod

Overview:
- 1-bit PDM stream to NBITS-wide unsigned PCM samples; the receive-side counterpart of the team's pdm modulator.
- Uses a 3rd-order CIC decimator with a power-of-two ratio, then scaling and saturation to full-scale unsigned.
- Sits after a PDM pad or loopback from the modulator. Produces one sample per DECIM accepted bits, with a one-cycle valid strobe.

Parameters:
- NBITS, 16, output sample width; unsigned, 0..2^NBITS-1.
- DECIM_LOG2, 6, log2 of decimation ratio R (R=64). Elaboration error if 3*DECIM_LOG2 < NBITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- din  in  1  PDM bit; 1 = +1, 0 = 0. Sampled only when din_en=1.
- din_en  in  1  bit-accept strobe. May be held high every cycle or gapped arbitrarily.
- dout  out  NBITS  decimated PCM sample; holds its value between strobes.
- dout_valid  out  1  one-cycle pulse when dout updates.

Behaviour:
- Internal width W = 3*DECIM_LOG2+1 (19 at defaults). All integrator and comb arithmetic is modulo 2^W; wrap-around is intended and must not be saturated.
- Reset values: integrators, comb delay registers, pipeline registers, bit counter and settle counter all = 0; dout = 0; dout_valid = 0.
- Integrators:
  - On each clk with din_en=1: I1 += din; I2 += I1(new); I3 += I2(new).
  - With din_en=0, state holds.
- Bit counter:
  - Counts accepted bits 0..R-1 and wraps to 0.
  - The edge that accepts the bit with counter==R-1 is the tick edge, call it T.
- Comb pipeline: one registered stage per clk, advancing independently of din_en.
  - T+1: capture I3.
  - T+2: C1 = x - x_prev1.
  - T+3: C2 = C1 - C1_prev.
  - T+4: C3 = C2 - C2_prev.
  - Each *_prev delay register updates only on its own stage's tick-advance.
- Output:
  - At T+5, dout is registered and dout_valid=1 for exactly one cycle.
  - Fixed latency is 5 clk from the tick edge.
  - Because R >= 2 and stages advance one per tick, pipelines from consecutive ticks never overlap.
- Scaling:
  - c = C3 taken as unsigned; range 0..2^(3*DECIM_LOG2).
  - y = c >> (3*DECIM_LOG2 - NBITS).
  - If y > 2^NBITS-1, dout = 2^NBITS-1 (saturate). This only occurs for an all-ones window.
- Transfer: steady duty cycle d gives dout = floor(d*2^NBITS), saturated at the top. The first two outputs after reset are partial (filter warm-up).
- Reset mid-operation:
  - Pending pipeline contents are discarded; no dout_valid follows from a pre-reset tick.
  - The first post-reset dout_valid occurs 5 clk after the R-th accepted post-reset bit.
- rst and din_en high together: rst wins; the bit is not accepted.
- din_en gaps: output value is unaffected; only timing stretches.

Optional Feature:
- Macro: PDM_DEMOD_SETTLE_EN.
- When defined:
  - A 2-bit settle counter suppresses dout_valid for the first 2 outputs after reset; dout stays 0 for them.
  - The first strobed sample is the 3rd, which is fully settled.
  - The counter saturates and is cleared only by rst.
- When undefined: every output is strobed, including the partial warm-up samples.

Decomposition:
- Shared package pdm_pkg:
  - CIC_ORDER=3.
  - Function cic_width(order, decim_log2) returning order*decim_log2+1.
  - Saturating-shift function used by the output stage.
  - NBITS default is shared with the modulator.
- Sub-module cic_integrator (one accumulator with enable, width W), instantiated 3x.
- Comb stages stay inline in pdm_demod.

Test Plan:
- din=0, din_en=1 constant for 4 outputs -> every dout_valid carries dout=0x0000; strobes are spaced exactly 64 clk apart.
- din=1 constant for 4 outputs -> outputs 1 and 2 partial; outputs 3 onward = 0xFFFF (saturated from 2^16). With PDM_DEMOD_SETTLE_EN, the first strobe is already 0xFFFF.
- din alternating 1,0 -> from output 3 onward, dout=0x8000 exactly.
- Loopback from the pdm modulator with its din=0x4000, rst released together -> settled outputs within 0x4000±1.
- din_en high every 3rd clk with din=1 -> same values as the continuous case; dout_valid 5 clk after each 64th accepted bit.
- rst asserted for 1 clk at bit 40 of a frame, then din=1 -> no strobe from the aborted frame; the next strobe occurs 64 accepted bits plus 5 clk after rst deasserts.
